// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter that sequences load/toggle writes from NREQ clients
// into one shared WIDTH-bit flip-flop bank, with synchronous bank clear.
module ff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         op,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    input  logic                    clr,
    output logic [NREQ-1:0]         gnt,
    output logic                    ack,
    output logic                    busy,
    output logic [WIDTH-1:0]        q,
    output logic [WIDTH-1:0]        qbar
);

    // state   | meaning
    // IDLE    | arbitrate among pending requests
    // APPLY   | write granted client's op into the bank, pulse ack
    // RELEASE | drop gnt/ack, advance round-robin pointer
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, RELEASE} state_t;

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      winner;
    logic [IW-1:0]      pick;
    logic               pick_valid;
    logic [WIDTH-1:0]   sel_data;
    logic               sel_op;
    int unsigned        idx;

    // First requester found scanning upward from ptr, wrapping at NREQ.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!pick_valid && req[idx]) begin
                pick       = IW'(idx);
                pick_valid = 1'b1;
            end
        end
    end

    assign sel_data = data_in[winner*WIDTH +: WIDTH];
    assign sel_op   = op[winner];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            ptr    <= '0;
            winner <= '0;
            gnt    <= '0;
            ack    <= 1'b0;
            q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner <= pick;
                        gnt    <= NREQ'(1) << pick;
                        state  <= APPLY;
                    end else begin
                        gnt <= '0;
                    end
                end
                APPLY: begin
                    ack   <= 1'b1;
                    state <= RELEASE;
                    q     <= sel_op ? (q ^ sel_data) : sel_data;
                end
                RELEASE: begin
                    gnt   <= '0;
                    ack   <= 1'b0;
                    ptr   <= (winner == IW'(NREQ-1)) ? '0 : winner + 1'b1;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    ack   <= 1'b0;
                    state <= IDLE;
                end
            endcase
            // clr overrides any same-cycle bank write; the FSM is unaffected.
            if (clr) q <= '0;
        end
    end

    assign busy = (state != IDLE);
    assign qbar = ~q;

endmodule
